// File: rtl/symbol_sorter_if.sv
// ----------------------------------------------------------------------------
// symbol_sorter_if
// Groups the request/result signals of symbol_sorter into one bundle.
//   start  : request a sort (master -> sorter)
//   num    : number of active channels, 4 bits (master -> sorter)
//   desc   : 1 = largest count first, 0 = smallest first (master -> sorter)
//   counts : N packed W-bit counts, channel k at [k*W +: W] (master -> sorter)
//   idx    : N packed IW-bit ranks, rank r at [r*IW +: IW] (sorter -> master)
//   busy   : sort in progress (sorter -> master)
//   done   : idx holds a completed result (sorter -> master)
// ----------------------------------------------------------------------------
interface symbol_sorter_if #(
   parameter int N  = 6,
   parameter int W  = 8,
   parameter int IW = 3
);
   logic            start;
   logic [3:0]      num;
   logic            desc;
   logic [N*W-1:0]  counts;
   logic [N*IW-1:0] idx;
   logic            busy;
   logic            done;

   modport master (output start, num, desc, counts, input idx, busy, done);
   modport slave  (input start, num, desc, counts, output idx, busy, done);
endinterface

// File: rtl/symbol_sorter.sv
// ----------------------------------------------------------------------------
// symbol_sorter
// Ranks up to N channel counts by repeated selection: every pass scans the
// active channels one per cycle, keeps the best not-yet-selected candidate
// and writes it to the next rank slot. The last pass also writes the single
// remaining channel, so a sort of n channels takes (n-1)*n SCAN cycles.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : symbol_sorter_if.slave (start/num/desc/counts in, idx/busy/done out)
// ----------------------------------------------------------------------------
module symbol_sorter #(
   parameter int N  = 6,
   parameter int W  = 8,
   parameter int IW = 3
) (
   input  logic           clk,
   input  logic           reset,
   symbol_sorter_if.slave bus
);
   localparam int             CW  = 4;
   localparam logic [CW-1:0]  N_C = CW'(N);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   state_t          state_r, state_s;
   logic [W-1:0]    cap_r [N];
   logic            desc_r;
   logic [CW-1:0]   n_r;
   logic [N-1:0]    mask_r;
   logic [IW-1:0]   cnt_r;
   logic [IW-1:0]   pass_r;
   logic            cand_valid_r;
   logic [IW-1:0]   cand_idx_r;
   logic [W-1:0]    cand_val_r;
   logic [IW-1:0]   idx_r [N];
   logic            busy_r;
   logic            done_r;

   logic [CW-1:0]   n_in_s;
   logic            accept_s;
   logic [W-1:0]    cur_val_s;
   logic            better_s;
   logic [IW-1:0]   win_idx_s;
   logic            last_s;
   logic            final_s;
   logic [IW-1:0]   rem_idx_s;

   assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));

   // Clamp the requested channel count to the number of physical channels.
   always_comb begin
      n_in_s = bus.num;
      if (bus.num > N_C) begin
         n_in_s = N_C;
      end else begin
         n_in_s = bus.num;
      end
   end

   // Candidate tracking: strict comparison keeps the lower index on ties.
   always_comb begin
      cur_val_s = cap_r[cnt_r];
      better_s  = 1'b0;
      if (mask_r[cnt_r]) begin
         better_s = 1'b0;
      end else if (!cand_valid_r) begin
         better_s = 1'b1;
      end else if (desc_r) begin
         better_s = (cur_val_s > cand_val_r);
      end else begin
         better_s = (cur_val_s < cand_val_r);
      end
      win_idx_s = better_s ? cnt_r : cand_idx_r;
      last_s    = (CW'(cnt_r) == (n_r - 4'd1));
      final_s   = last_s && (CW'(pass_r) == (n_r - 4'd2));
   end

   // Lowest active channel that is neither selected nor this pass's winner.
   always_comb begin
      rem_idx_s = '0;
      for (int k = N - 1; k >= 0; k--) begin
         rem_idx_s = ((CW'(k) < n_r) && !mask_r[k] && (IW'(k) != win_idx_s))
                     ? IW'(k) : rem_idx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               state_s = (n_in_s < 4'd2) ? DONE : SCAN;
            end else begin
               state_s = state_r;
            end
         end
         SCAN: begin
            if (final_s) begin
               state_s = DONE;
            end else begin
               state_s = SCAN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register with registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == SCAN);
         done_r  <= (state_s == DONE);
      end
   end

   // Capture on accept, then one scan step per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         desc_r       <= 1'b0;
         n_r          <= 4'd0;
         mask_r       <= '0;
         cnt_r        <= '0;
         pass_r       <= '0;
         cand_valid_r <= 1'b0;
         cand_idx_r   <= '0;
         cand_val_r   <= '0;
         for (int r = 0; r < N; r++) begin
            cap_r[r] <= '0;
            idx_r[r] <= IW'(r);
         end
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (accept_s) begin
                  desc_r       <= bus.desc;
                  n_r          <= n_in_s;
                  mask_r       <= '0;
                  cnt_r        <= '0;
                  pass_r       <= '0;
                  cand_valid_r <= 1'b0;
                  cand_idx_r   <= '0;
                  cand_val_r   <= '0;
                  // Unused rank slots read back as their own index.
                  for (int r = 0; r < N; r++) begin
                     cap_r[r] <= bus.counts[r*W +: W];
                     idx_r[r] <= IW'(r);
                  end
               end
            end
            SCAN: begin
               if (last_s) begin
                  idx_r[pass_r]     <= win_idx_s;
                  mask_r[win_idx_s] <= 1'b1;
                  pass_r            <= pass_r + IW'(1);
                  cnt_r             <= '0;
                  cand_valid_r      <= 1'b0;
                  cand_idx_r        <= '0;
                  cand_val_r        <= '0;
                  if (final_s) begin
                     idx_r[n_r - 4'd1] <= rem_idx_s;
                  end
               end else begin
                  cnt_r <= cnt_r + IW'(1);
                  if (better_s) begin
                     cand_valid_r <= 1'b1;
                     cand_idx_r   <= cnt_r;
                     cand_val_r   <= cur_val_s;
                  end
               end
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   genvar g;
   for (g = 0; g < N; g++) begin : g_idx
      assign bus.idx[g*IW +: IW] = idx_r[g];
   end
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
